regfile_np: RTL and testbench

- Next-generation CPU register file.
- Parametrised in data width, depth and number of read ports; one write port.
- Storage is a plain array with no per-entry reset, so it can map to distributed RAM.
- Clearing is done by a sequential clear engine, run at reset and on request. Optional zero register. Optional write-to-read bypass.
- Sits between decode (read addresses) and writeback (write port) of the bexkat core.

---
 rtl/regfile_np.sv | 153 +++++++++++++++
 tb/tb_regfile_np.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_np.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_np
// Purpose  : Parametrised CPU register file, one write port and NREAD
//            combinational read ports. Storage has no per-entry reset; a
//            sequential clear engine zeroes it after reset and on request.
// Ports    : clk, rst (async, active-high)
//            clear_req           - start a full clear (pulse, IDLE only)
//            busy                - clear engine running (registered)
//            write_en/addr/data  - write port; write_ok reports acceptance
//            read_addr/read_data - packed read ports, port k at slice k
// Options  : REGFILE_BYPASS_EN - forward same-cycle write data to matching
//            read ports (write-through).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_np #(
    parameter int WIDTH   = 16,
    parameter int AWIDTH  = 5,
    parameter int NREAD   = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_req,
    output logic                    busy,
    input  logic                    write_en,
    input  logic [AWIDTH-1:0]       write_addr,
    input  logic [WIDTH-1:0]        write_data,
    output logic                    write_ok,
    input  logic [NREAD*AWIDTH-1:0] read_addr,
    output logic [NREAD*WIDTH-1:0]  read_data
);

    localparam int DEPTH = 2**AWIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [AWIDTH-1:0] LAST_PTR = {AWIDTH{1'b1}};

    logic [0:0]        state_q, state_d;
    logic [AWIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy_q, busy_d;

    // Plain storage array, no reset, so it can map onto distributed RAM.
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              mem_we;
    logic [AWIDTH-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;
    logic              idle;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                // Pointer wraps to 0 on the final step, ready for the next clear.
                clr_ptr_d = clr_ptr_q + AWIDTH'(1);
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // ------------------------------------------------------------------
    // Output / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        idle     = (state_q == ST_IDLE);
        // A same-cycle clear request wins over the write.
        write_ok = write_en & idle & ~clear_req;
        if (!idle) begin
            mem_we = 1'b1;
            mem_wa = clr_ptr_q;
            mem_wd = '0;
        end else begin
            // Writes to the zero register are acknowledged but discarded.
            mem_we = write_ok & ~((ZERO_R0 != 0) && (write_addr == '0));
            mem_wa = write_addr;
            mem_wd = write_data;
        end
    end

    assign busy = busy_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AWIDTH-1:0] ra;
        logic [WIDTH-1:0]  rd;

        assign ra = read_addr[k*AWIDTH +: AWIDTH];

        always_comb begin
            rd = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
            // write_ok is already low while clearing, so no bypass when busy.
            if (write_ok && (ra == write_addr)) begin
                rd = write_data;
            end
`endif
            if (!idle) begin
                rd = '0;
            end
            if ((ZERO_R0 != 0) && (ra == '0)) begin
                rd = '0;
            end
        end

        assign read_data[k*WIDTH +: WIDTH] = rd;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_np.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_np
// Purpose  : Self-checking bench for regfile_np. Two instances share the
//            stimulus: dut_a (ZERO_R0=0) and dut_z (ZERO_R0=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_np;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [15:0] write_data;
    logic [9:0]  read_addr;

    logic        busy_a, ok_a, busy_z, ok_z;
    logic [31:0] rd_a, rd_z;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_np #(.WIDTH(16), .AWIDTH(5), .NREAD(2), .ZERO_R0(0)) dut_a (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_a),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .write_ok(ok_a), .read_addr(read_addr), .read_data(rd_a)
    );

    regfile_np #(.WIDTH(16), .AWIDTH(5), .NREAD(2), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_z),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .write_ok(ok_z), .read_addr(read_addr), .read_data(rd_z)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        ok;
        logic [15:0] e0;   // expected without bypass
        logic [15:0] e1;
        logic [15:0] b0;   // expected with bypass
        logic [15:0] b1;
    } vec_t;

    vec_t vecs [10];
    vec_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one clear from its first busy cycle to completion. Writes, a
    // repeated clear_req and a bypass-capable read are presented throughout.
    task automatic run_clear(input string tag);
        int na, nz, bad;
        na = 0; nz = 0; bad = 0;
        write_en   = 1'b1;
        write_addr = 5'd9;
        write_data = 16'h9999;
        read_addr  = {5'd9, 5'd7};
        for (int i = 0; i < 100 && (busy_a || busy_z); i++) begin
            if (busy_a) na++;
            if (busy_z) nz++;
            if (ok_a || ok_z || rd_a != 32'h0 || rd_z != 32'h0) bad++;
            clear_req = (i == 5);
            @(negedge clk); #1;
        end
        write_en  = 1'b0;
        clear_req = 1'b0;
        check({tag, "_busy_edges_a"}, na, 32);
        check({tag, "_busy_edges_z"}, nz, 32);
        check({tag, "_activity_while_busy"}, bad, 0);
    endtask

    task automatic check_all_zero(input string tag);
        int bad;
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            read_addr = {5'(31 - a), 5'(a)};
            #1;
            if (rd_a != 32'h0 || rd_z != 32'h0) bad++;
        end
        check({tag, "_nonzero_entries"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        logic [15:0] e0, e1, z0, z1;

        //          we    wa     wd        ra0    ra1    ok    e0        e1        b0        b1
        vecs[0] = '{1'b1, 5'd7,  16'hBEEF, 5'd7,  5'd31, 1'b1, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b1, 5'd31, 16'h1234, 5'd31, 5'd7,  1'b1, 16'h0000, 16'hBEEF, 16'h1234, 16'hBEEF};
        vecs[2] = '{1'b0, 5'd0,  16'h0000, 5'd31, 5'd7,  1'b0, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
        vecs[3] = '{1'b0, 5'd0,  16'h0000, 5'd7,  5'd31, 1'b0, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234};
        vecs[4] = '{1'b1, 5'd3,  16'h0001, 5'd3,  5'd3,  1'b1, 16'h0000, 16'h0000, 16'h0001, 16'h0001};
        vecs[5] = '{1'b1, 5'd3,  16'h00AA, 5'd3,  5'd7,  1'b1, 16'h0001, 16'hBEEF, 16'h00AA, 16'hBEEF};
        vecs[6] = '{1'b0, 5'd0,  16'h0000, 5'd3,  5'd3,  1'b0, 16'h00AA, 16'h00AA, 16'h00AA, 16'h00AA};
        vecs[7] = '{1'b1, 5'd0,  16'hFFFF, 5'd0,  5'd3,  1'b1, 16'h0000, 16'h00AA, 16'hFFFF, 16'h00AA};
        vecs[8] = '{1'b1, 5'd5,  16'h0F0F, 5'd0,  5'd5,  1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0F0F};
        vecs[9] = '{1'b0, 5'd0,  16'h0000, 5'd5,  5'd0,  1'b0, 16'h0F0F, 16'hFFFF, 16'h0F0F, 16'hFFFF};

        // ---------------- reset ----------------
        rst        = 1'b1;
        clear_req  = 1'b0;
        write_en   = 1'b1;
        write_addr = 5'd5;
        write_data = 16'h1111;
        read_addr  = {5'd3, 5'd0};
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy_a", busy_a, 1);
        check("reset_busy_z", busy_z, 1);
        check("reset_write_ok", {ok_a, ok_z}, 0);
        check("reset_read_a", rd_a, 0);
        check("reset_read_z", rd_z, 0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        run_clear("reset_clear");
        check_all_zero("after_reset");

        // ---------------- table vectors ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            write_en   = vecs[i].we;
            write_addr = vecs[i].wa;
            write_data = vecs[i].wd;
            read_addr  = {vecs[i].ra1, vecs[i].ra0};
            exp_q.push_back(vecs[i]);
            #1;
            v = exp_q.pop_front();
`ifdef REGFILE_BYPASS_EN
            e0 = v.b0; e1 = v.b1;
`else
            e0 = v.e0; e1 = v.e1;
`endif
            z0 = (v.ra0 == 5'd0) ? 16'h0000 : e0;
            z1 = (v.ra1 == 5'd0) ? 16'h0000 : e1;
            check($sformatf("vec%0d_write_ok_a", i), ok_a, v.ok);
            check($sformatf("vec%0d_write_ok_z", i), ok_z, v.ok);
            check($sformatf("vec%0d_port0_a", i), rd_a[15:0], e0);
            check($sformatf("vec%0d_port1_a", i), rd_a[31:16], e1);
            check($sformatf("vec%0d_port0_z", i), rd_z[15:0], z0);
            check($sformatf("vec%0d_port1_z", i), rd_z[31:16], z1);
        end
        @(negedge clk);
        write_en = 1'b0;

        // ---------------- clear request beats a same-cycle write ----------------
        clear_req  = 1'b1;
        write_en   = 1'b1;
        write_addr = 5'd5;
        write_data = 16'h5555;
        read_addr  = {5'd5, 5'd7};
        #1;
        check("clrreq_write_ok_a", ok_a, 0);
        check("clrreq_write_ok_z", ok_z, 0);
        check("clrreq_busy_before_edge", busy_a, 0);
        check("clrreq_read_still_valid", rd_a, {16'h0F0F, 16'hBEEF});
        @(negedge clk);
        clear_req = 1'b0;
        write_en  = 1'b0;
        #1;
        run_clear("clear_req");
        check_all_zero("after_clear_req");

        // ---------------- reset mid-clear ----------------
        @(negedge clk);
        write_en   = 1'b1;
        write_addr = 5'd20;
        write_data = 16'h2020;
        read_addr  = {5'd20, 5'd20};
        #1;
        check("pre_midclr_write_ok", ok_a, 1);
        @(negedge clk);
        write_en  = 1'b0;
        clear_req = 1'b1;
        #1;
        check("pre_midclr_read", rd_a[15:0], 16'h2020);
        @(negedge clk);
        clear_req = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midclr_rst_busy", busy_a, 1);
        check("midclr_rst_read", rd_a, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        run_clear("midclr_reset");
        check_all_zero("after_midclr_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
